// File: rtl/fifo_rd_ctrl_if.sv
`timescale 1ns/1ps
// fifo_rd_ctrl_if
// Bundles the signals between the FIFO read controller, the storage
// array, the write-side pointer logic and the downstream consumer.
//   wr_ptr     : write pointer from the write side (binary, wrap bit on top)
//   mem_data   : storage read data, valid the cycle after rd_en
//   dout_ready : consumer accepts dout this cycle
//   rd_en      : storage read strobe
//   rd_addr    : storage read address
//   rd_ptr     : registered read pointer, returned to the write side
//   dout       : output word
//   dout_valid : dout holds a valid word
//   empty      : no unread word in storage
//   count      : unread words in storage, 0..16
//   ptr_err    : sticky pointer-distance error
// master = the read controller, slave = its environment.
interface fifo_rd_ctrl_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter int PTR_W  = ADDR_W + 1
);
    logic [PTR_W-1:0]  wr_ptr;
    logic [DATA_W-1:0] mem_data;
    logic              dout_ready;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [DATA_W-1:0] dout;
    logic              dout_valid;
    logic              empty;
    logic [PTR_W-1:0]  count;
    logic              ptr_err;

    modport master (
        input  wr_ptr, mem_data, dout_ready,
        output rd_en, rd_addr, rd_ptr, dout, dout_valid, empty, count, ptr_err
    );

    modport slave (
        output wr_ptr, mem_data, dout_ready,
        input  rd_en, rd_addr, rd_ptr, dout, dout_valid, empty, count, ptr_err
    );
endinterface

// File: rtl/fifo_rd_ctrl.sv
`timescale 1ns/1ps
// fifo_rd_ctrl
// Read-side controller of a 16-entry FIFO. Owns the read pointer, issues
// reads to a synchronous-read storage array (1-cycle latency) and presents
// words first-word-fall-through through a 2-entry output buffer (output
// register + skid register) so that one word per cycle can be sustained.
// Ports:
//   clk   : clock, all state updates on the rising edge
//   clear : asynchronous active-low reset
//   bus   : fifo_rd_ctrl_if.master (see interface file for signal list)
module fifo_rd_ctrl #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter int PTR_W  = ADDR_W + 1
) (
    input  logic           clk,
    input  logic           clear,
    fifo_rd_ctrl_if.master bus
);

    // Output buffer occupancy: nothing, dout only, dout plus skid.
    localparam logic [1:0] OUT0 = 2'd0;
    localparam logic [1:0] OUT1 = 2'd1;
    localparam logic [1:0] OUT2 = 2'd2;

    localparam logic [PTR_W-1:0] DEPTH = PTR_W'(1 << ADDR_W);

    logic [1:0]        out_state;
    logic [1:0]        out_state_nxt;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [DATA_W-1:0] dout_q;
    logic [DATA_W-1:0] skid_q;
    logic [DATA_W-1:0] dout_nxt;
    logic              fetch_pend;
    logic              ptr_err_q;

    logic              dout_valid_w;
    logic              skid_valid;
    logic              pop;
    logic              land;
    logic [1:0]        held;
    logic [1:0]        held_after_pop;
    logic [PTR_W-1:0]  count_w;
    logic              empty_w;
    logic              over_w;
    logic              rd_en_w;
    logic              dout_load;
    logic              dout_from_skid;
    logic              skid_load;

    // Occupancy view derived from the buffer state; a fetch in flight also
    // claims a slot so the buffer can never be overrun.
    always_comb begin
        dout_valid_w   = (out_state != OUT0);
        skid_valid     = (out_state == OUT2);
        pop            = dout_valid_w & bus.dout_ready;
        land           = fetch_pend;
        held           = {1'b0, dout_valid_w} + {1'b0, skid_valid} + {1'b0, fetch_pend};
        held_after_pop = held - {1'b0, pop};
    end

    // Storage occupancy from the registered pointers. A distance above the
    // depth can only come from a corrupted pointer, flagged as an error.
    // Equal addresses with differing wrap bits mean full, not empty.
    always_comb begin
        count_w = bus.wr_ptr - rd_ptr_q;
        empty_w = (bus.wr_ptr == rd_ptr_q);
        over_w  = (count_w > DEPTH);
    end

    // Read strobe. Suppressed while in reset so nothing is fetched into a
    // buffer that is being held cleared.
    always_comb begin
        rd_en_w = clear & ~empty_w & (held_after_pop < 2'd2) & ~ptr_err_q;
    end

    // Output buffer transitions. The skid register always holds the older
    // word, so on a pop it moves to dout before any landing fetch does.
    always_comb begin
        out_state_nxt  = out_state;
        dout_load      = 1'b0;
        dout_from_skid = 1'b0;
        skid_load      = 1'b0;
        case (out_state)
            OUT0: begin
                if (land) begin
                    dout_load     = 1'b1;
                    out_state_nxt = OUT1;
                end
            end
            OUT1: begin
                if (pop && land) begin
                    dout_load = 1'b1;
                end else if (pop) begin
                    out_state_nxt = OUT0;
                end else if (land) begin
                    skid_load     = 1'b1;
                    out_state_nxt = OUT2;
                end
            end
            OUT2: begin
                if (pop) begin
                    dout_load      = 1'b1;
                    dout_from_skid = 1'b1;
                    if (land) begin
                        skid_load = 1'b1;
                    end else begin
                        out_state_nxt = OUT1;
                    end
                end
            end
            default: begin
                out_state_nxt = OUT0;
            end
        endcase
        dout_nxt = dout_from_skid ? skid_q : bus.mem_data;
    end

    // Read pointer and fetch tracking; the storage returns data one cycle
    // after the strobe, which is exactly when fetch_pend is high.
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            rd_ptr_q   <= '0;
            fetch_pend <= 1'b0;
        end else begin
            if (rd_en_w) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            fetch_pend <= rd_en_w;
        end
    end

    // Output buffer registers. dout keeps its last word when it empties.
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            out_state <= OUT0;
            dout_q    <= '0;
            skid_q    <= '0;
        end else begin
            out_state <= out_state_nxt;
            if (dout_load) begin
                dout_q <= dout_nxt;
            end
            if (skid_load) begin
                skid_q <= bus.mem_data;
            end
        end
    end

    // Sticky pointer error; only reset clears it.
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            ptr_err_q <= 1'b0;
        end else if (over_w) begin
            ptr_err_q <= 1'b1;
        end
    end

    assign bus.rd_en      = rd_en_w;
    assign bus.rd_addr    = rd_ptr_q[ADDR_W-1:0];
    assign bus.rd_ptr     = rd_ptr_q;
    assign bus.dout       = dout_q;
    assign bus.dout_valid = dout_valid_w;
    assign bus.empty      = empty_w;
    assign bus.count      = count_w;
    assign bus.ptr_err    = ptr_err_q;

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
`timescale 1ns/1ps
// tb_fifo_rd_ctrl
// Self-checking bench for fifo_rd_ctrl. The bench plays the write side
// and the synchronous-read storage array; every written word is queued in
// order and each popped word must match the head of that queue.
module tb_fifo_rd_ctrl;

    logic clk;
    logic clear;
    int   tests_run;
    int   tests_failed;

    logic [7:0] mem [16];
    logic [7:0] exp_q [$];

    fifo_rd_ctrl_if #(.DATA_W(8), .ADDR_W(4), .PTR_W(5)) bus ();

    fifo_rd_ctrl #(.DATA_W(8), .ADDR_W(4), .PTR_W(5)) dut (
        .clk   (clk),
        .clear (clear),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Storage array model: synchronous read with one cycle latency.
    always @(posedge clk) begin
        if (!clear) begin
            bus.mem_data <= 8'h00;
        end else if (bus.rd_en) begin
            bus.mem_data <= mem[bus.rd_addr];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [7:0] d);
        mem[bus.wr_ptr[3:0]] = d;
        exp_q.push_back(d);
        bus.wr_ptr = bus.wr_ptr + 5'd1;
    endtask

    task automatic do_reset();
        bus.dout_ready = 1'b0;
        bus.wr_ptr     = 5'd0;
        clear          = 1'b0;
        exp_q.delete();
        tick();
        tick();
        clear = 1'b1;
    endtask

    task automatic test_reset();
        tick();
        tests_run++;
        if (bus.rd_ptr !== 5'd0 || bus.dout_valid !== 1'b0 || bus.dout !== 8'h00 ||
            bus.rd_en !== 1'b0 || bus.ptr_err !== 1'b0 || bus.empty !== 1'b1 || bus.count !== 5'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset_state: rd_ptr=%0d dout_valid=%b dout=%h rd_en=%b ptr_err=%b empty=%b count=%0d, required 0 0 00 0 0 1 0",
                     bus.rd_ptr, bus.dout_valid, bus.dout, bus.rd_en, bus.ptr_err, bus.empty, bus.count);
        end
        clear = 1'b1;
    endtask

    task automatic test_single_word();
        do_reset();
        write_word(8'hA5);
        @(negedge clk);
        tests_run++;
        if (bus.rd_en !== 1'b1 || bus.rd_addr !== 4'd0) begin
            tests_failed++;
            $display("[TB] FAIL single_issue: rd_en=%b rd_addr=%0d, required 1 0", bus.rd_en, bus.rd_addr);
        end
        tick();
        tests_run++;
        if (bus.dout_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL single_early_valid: dout_valid=%b, required 0", bus.dout_valid);
        end
        tick();
        tests_run++;
        if (bus.dout !== 8'hA5 || bus.dout_valid !== 1'b1 || bus.rd_ptr !== 5'd1 || bus.empty !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL single_word: dout=%h valid=%b rd_ptr=%0d empty=%b, required a5 1 1 1",
                     bus.dout, bus.dout_valid, bus.rd_ptr, bus.empty);
        end
        bus.dout_ready = 1'b1;
        tick();
        bus.dout_ready = 1'b0;
        tests_run++;
        if (bus.dout_valid !== 1'b0 || bus.dout !== 8'hA5) begin
            tests_failed++;
            $display("[TB] FAIL single_pop: dout_valid=%b dout=%h, required 0 a5", bus.dout_valid, bus.dout);
        end
    endtask

    task automatic test_backpressure();
        int reads;
        do_reset();
        for (int i = 0; i < 5; i++) write_word(8'(i + 1));
        reads = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.rd_en === 1'b1) reads++;
            tick();
        end
        tests_run++;
        if (reads != 2 || bus.dout !== 8'h01 || bus.dout_valid !== 1'b1 || bus.count !== 5'd3) begin
            tests_failed++;
            $display("[TB] FAIL backpressure_hold: reads=%0d dout=%h valid=%b count=%0d, required 2 01 1 3",
                     reads, bus.dout, bus.dout_valid, bus.count);
        end
        bus.dout_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            tests_run++;
            if (bus.dout_valid !== 1'b1 || bus.dout !== exp_q[0]) begin
                tests_failed++;
                $display("[TB] FAIL backpressure_drain[%0d]: valid=%b dout=%h, required 1 %h",
                         i, bus.dout_valid, bus.dout, exp_q[0]);
            end
            void'(exp_q.pop_front());
            tick();
        end
        bus.dout_ready = 1'b0;
        tests_run++;
        if (bus.dout_valid !== 1'b0 || bus.empty !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL backpressure_end: valid=%b empty=%b, required 0 1", bus.dout_valid, bus.empty);
        end
    endtask

    task automatic test_full();
        int pops;
        do_reset();
        for (int i = 0; i < 16; i++) write_word(8'h40 + 8'(i));
        @(negedge clk);
        tests_run++;
        if (bus.count !== 5'd16 || bus.empty !== 1'b0 || bus.rd_en !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL full_state: count=%0d empty=%b rd_en=%b, required 16 0 1",
                     bus.count, bus.empty, bus.rd_en);
        end
        tick();
        bus.dout_ready = 1'b1;
        pops = 0;
        for (int c = 0; c < 40 && exp_q.size() > 0; c++) begin
            @(negedge clk);
            if (bus.dout_valid === 1'b1) begin
                tests_run++;
                if (bus.dout !== exp_q[0]) begin
                    tests_failed++;
                    $display("[TB] FAIL full_drain: dout=%h, required %h", bus.dout, exp_q[0]);
                end
                void'(exp_q.pop_front());
                pops++;
            end
            tick();
        end
        bus.dout_ready = 1'b0;
        tests_run++;
        if (pops != 16) begin
            tests_failed++;
            $display("[TB] FAIL full_count: popped=%0d, required 16", pops);
        end
    endtask

    task automatic test_streaming_wrap();
        int written, pops, first_pop, gaps;
        bit saw_mid, saw_wrap;
        logic [4:0] prev_ptr;
        do_reset();
        bus.dout_ready = 1'b1;
        written = 0; pops = 0; first_pop = -1; gaps = 0;
        saw_mid = 0; saw_wrap = 0;
        prev_ptr = bus.rd_ptr;
        for (int c = 0; c < 60; c++) begin
            if (written < 40 && 5'(bus.wr_ptr - bus.rd_ptr) < 5'd16) begin
                write_word(8'(written * 7 + 3));
                written++;
            end
            @(negedge clk);
            if (bus.dout_valid === 1'b1 && exp_q.size() > 0) begin
                tests_run++;
                if (bus.dout !== exp_q[0]) begin
                    tests_failed++;
                    $display("[TB] FAIL stream_data: dout=%h, required %h", bus.dout, exp_q[0]);
                end
                void'(exp_q.pop_front());
                if (first_pop < 0) first_pop = c;
                pops++;
            end else if (first_pop >= 0 && pops < 40) begin
                gaps++;
            end
            tick();
            if (prev_ptr == 5'd15 && bus.rd_ptr == 5'd16) saw_mid = 1;
            if (prev_ptr == 5'd31 && bus.rd_ptr == 5'd0) saw_wrap = 1;
            prev_ptr = bus.rd_ptr;
        end
        bus.dout_ready = 1'b0;
        tests_run++;
        if (pops != 40 || first_pop != 2 || gaps != 0) begin
            tests_failed++;
            $display("[TB] FAIL stream_rate: pops=%0d first=%0d gaps=%0d, required 40 2 0", pops, first_pop, gaps);
        end
        tests_run++;
        if (!saw_mid || !saw_wrap) begin
            tests_failed++;
            $display("[TB] FAIL stream_wrap: 15->16 seen=%0d 31->0 seen=%0d, required 1 1", saw_mid, saw_wrap);
        end
    endtask

    task automatic test_ptr_err();
        do_reset();
        write_word(8'h11);
        write_word(8'h22);
        repeat (4) tick();
        bus.wr_ptr = bus.rd_ptr + 5'd20;
        @(negedge clk);
        tests_run++;
        if (bus.ptr_err !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL err_not_early: ptr_err=%b, required 0", bus.ptr_err);
        end
        tick();
        tests_run++;
        if (bus.ptr_err !== 1'b1 || bus.rd_en !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL err_set: ptr_err=%b rd_en=%b, required 1 0", bus.ptr_err, bus.rd_en);
        end
        bus.dout_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            tests_run++;
            if (bus.dout_valid !== 1'b1 || bus.dout !== exp_q[0]) begin
                tests_failed++;
                $display("[TB] FAIL err_drain[%0d]: valid=%b dout=%h, required 1 %h",
                         i, bus.dout_valid, bus.dout, exp_q[0]);
            end
            void'(exp_q.pop_front());
            tick();
        end
        repeat (3) tick();
        tests_run++;
        if (bus.dout_valid !== 1'b0 || bus.rd_en !== 1'b0 || bus.rd_ptr !== 5'd2) begin
            tests_failed++;
            $display("[TB] FAIL err_stall: valid=%b rd_en=%b rd_ptr=%0d, required 0 0 2",
                     bus.dout_valid, bus.rd_en, bus.rd_ptr);
        end
        bus.dout_ready = 1'b0;
        bus.wr_ptr = bus.rd_ptr;
        tick();
        tests_run++;
        if (bus.ptr_err !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL err_sticky: ptr_err=%b, required 1", bus.ptr_err);
        end
        #2;
        clear = 1'b0;
        #1;
        tests_run++;
        if (bus.ptr_err !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL err_clear: ptr_err=%b, required 0", bus.ptr_err);
        end
        clear = 1'b1;
    endtask

    task automatic test_reset_mid();
        bit reached;
        do_reset();
        bus.dout_ready = 1'b1;
        for (int i = 0; i < 9; i++) write_word(8'h80 + 8'(i));
        reached = 0;
        for (int c = 0; c < 20 && !reached; c++) begin
            tick();
            if (bus.rd_ptr == 5'd7 && bus.dout_valid === 1'b1) reached = 1;
        end
        tests_run++;
        if (!reached) begin
            tests_failed++;
            $display("[TB] FAIL mid_setup: rd_ptr=%0d valid=%b, required 7 1", bus.rd_ptr, bus.dout_valid);
        end
        #2;
        clear = 1'b0;
        #1;
        tests_run++;
        if (bus.rd_ptr !== 5'd0 || bus.dout_valid !== 1'b0 || bus.dout !== 8'h00 || bus.rd_en !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL mid_reset: rd_ptr=%0d valid=%b dout=%h rd_en=%b, required 0 0 00 0",
                     bus.rd_ptr, bus.dout_valid, bus.dout, bus.rd_en);
        end
        bus.wr_ptr = 5'd0;
        exp_q.delete();
        tick();
        clear = 1'b1;
        for (int i = 0; i < 3; i++) write_word(8'hC0 + 8'(i));
        for (int c = 0; c < 12 && exp_q.size() > 0; c++) begin
            @(negedge clk);
            if (bus.dout_valid === 1'b1) begin
                tests_run++;
                if (bus.dout !== exp_q[0]) begin
                    tests_failed++;
                    $display("[TB] FAIL mid_resume: dout=%h, required %h", bus.dout, exp_q[0]);
                end
                void'(exp_q.pop_front());
            end
            tick();
        end
        bus.dout_ready = 1'b0;
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("[TB] FAIL mid_resume_count: left=%0d, required 0", exp_q.size());
        end
    endtask

    task automatic test_random();
        int n;
        logic [4:0] diff;
        do_reset();
        for (int c = 0; c < 800; c++) begin
            bus.dout_ready = ($urandom_range(0, 3) != 0);
            n = $urandom_range(0, 2);
            for (int k = 0; k < n; k++) begin
                if (5'(bus.wr_ptr - bus.rd_ptr) < 5'd16) write_word(8'($urandom));
            end
            @(negedge clk);
            diff = bus.wr_ptr - bus.rd_ptr;
            tests_run++;
            if (bus.count !== diff || bus.empty !== (diff == 5'd0 && bus.wr_ptr == bus.rd_ptr) ||
                bus.rd_addr !== bus.rd_ptr[3:0] || (bus.rd_en === 1'b1 && diff == 5'd0)) begin
                tests_failed++;
                $display("[TB] FAIL rand_ptrs: count=%0d empty=%b rd_addr=%0d rd_en=%b, required count=%0d empty=%b rd_addr=%0d",
                         bus.count, bus.empty, bus.rd_addr, bus.rd_en, diff, (diff == 5'd0), bus.rd_ptr[3:0]);
            end
            if (bus.dout_valid === 1'b1 && bus.dout_ready === 1'b1) begin
                tests_run++;
                if (exp_q.size() == 0) begin
                    tests_failed++;
                    $display("[TB] FAIL rand_spurious: dout=%h, required no word", bus.dout);
                end else begin
                    if (bus.dout !== exp_q[0]) begin
                        tests_failed++;
                        $display("[TB] FAIL rand_data: dout=%h, required %h", bus.dout, exp_q[0]);
                    end
                    void'(exp_q.pop_front());
                end
            end
            tick();
        end
        bus.dout_ready = 1'b1;
        for (int c = 0; c < 60 && exp_q.size() > 0; c++) begin
            @(negedge clk);
            if (bus.dout_valid === 1'b1) begin
                tests_run++;
                if (bus.dout !== exp_q[0]) begin
                    tests_failed++;
                    $display("[TB] FAIL rand_drain: dout=%h, required %h", bus.dout, exp_q[0]);
                end
                void'(exp_q.pop_front());
            end
            tick();
        end
        bus.dout_ready = 1'b0;
        tests_run++;
        if (exp_q.size() != 0 || bus.ptr_err !== 1'b0 || bus.empty !== 1'b1 || bus.dout_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL rand_end: left=%0d ptr_err=%b empty=%b valid=%b, required 0 0 1 0",
                     exp_q.size(), bus.ptr_err, bus.empty, bus.dout_valid);
        end
    endtask

    initial begin
        tests_run      = 0;
        tests_failed   = 0;
        clear          = 1'b0;
        bus.wr_ptr     = 5'd0;
        bus.dout_ready = 1'b0;
        test_reset();
        test_single_word();
        test_backpressure();
        test_full();
        test_streaming_wrap();
        test_ptr_err();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/fifo_rd_ctrl.md
Name: fifo_rd_ctrl

Overview:
Read-side controller for the 16-entry FIFO. It owns the 5-bit read pointer (4-bit address plus wrap bit) and compares it against the write pointer from the write side. It issues reads to the synchronous-read storage array (1-cycle latency) and presents words to the consumer through a first-word-fall-through valid/ready output. A 2-entry output buffer (output register plus skid register) sustains one word per cycle.

Parameters:
DATA_W, 8, width of FIFO data word
ADDR_W, 4, storage address width; depth = 2**ADDR_W = 16
PTR_W, 5, pointer width = ADDR_W+1; bit 4 is the wrap bit

Ports:
clk  input  1  clock; all state updates on the rising edge
clear  input  1  asynchronous active-low reset; 0 resets all state immediately
wr_ptr  input  5  write pointer from the write-side pointer register; binary; same clock domain
mem_data  input  DATA_W  storage read data; valid the cycle after rd_en
dout_ready  input  1  consumer accepts dout this cycle
rd_en  output  1  storage read strobe (combinational)
rd_addr  output  4  storage read address = rd_ptr[3:0]
rd_ptr  output  5  registered read pointer, fed back to the write side for full detection
dout  output  DATA_W  registered output word
dout_valid  output  1  dout holds a valid word
empty  output  1  storage holds no unread word (wr_ptr == rd_ptr), combinational
count  output  5  unread words in storage = (wr_ptr - rd_ptr) mod 32, range 0..16
ptr_err  output  1  sticky: set when count > 16 is observed

Behaviour:
- Reset (clear=0, asynchronous): rd_ptr=0, dout=0, dout_valid=0, skid register empty, fetch_pend=0, ptr_err=0. Outputs are frozen while clear=0. Deassertion takes effect at the next rising edge.
- pop = dout_valid & dout_ready.
- held = dout_valid + skid_valid + fetch_pend, range 0..2.
- rd_en = !empty & ((held - pop) < 2) & !ptr_err.
- On rd_en: rd_ptr <= rd_ptr + 1. This wraps 31 -> 0 and flips the wrap bit every 16 reads. fetch_pend <= 1. If rd_en is low, fetch_pend <= 0.
- Data landing, on the edge after rd_en while fetch_pend=1:
  - If the output slot is empty after this cycle's pop, dout <= mem_data and dout_valid <= 1.
  - Otherwise skid <= mem_data.
- Pop with skid valid: dout <= skid. If a fetch lands in the same cycle, skid <= mem_data; otherwise the skid register empties.
- Pop with skid empty and no landing fetch: dout_valid <= 0. dout keeps its last value.
- Word order is strictly preserved: skid is older than a landing fetch.
- FSM, by words held in the output buffer:
  - OUT0: dout_valid=0.
  - OUT1: dout only.
  - OUT2: dout and skid.
  - fetch_pend is orthogonal. The rd_en rule prevents any overflow beyond 2.
- Latency: a word written into empty storage (wr_ptr changes at edge N) gives rd_en in cycle N. dout_valid=1 after edge N+2.
- Throughput: with dout_ready held at 1 and storage non-empty, one pop per cycle in steady state.
- empty and count use the current registered rd_ptr. A read issued this cycle is reflected next cycle.
- Wrap: wr_ptr=rd_ptr with differing bit 4 means full, count=16. This block treats that as non-empty.
- ptr_err:
  - Set when (wr_ptr - rd_ptr) mod 32 > 16.
  - While set, rd_en is held 0 and buffered words still drain.
  - Cleared only by reset.
- dout_ready while dout_valid=0: ignored, no state change.

Test Plan:
- Reset: clear=0 mid-operation with dout_valid=1, rd_ptr=7 -> immediately rd_ptr=0, dout_valid=0, dout=0, rd_en=0; resumes cleanly after clear=1.
- Single word: wr_ptr 0->1 with mem[0]=0xA5, dout_ready=0 -> rd_en=1 with rd_addr=0 in that cycle; dout=0xA5, dout_valid=1 two edges later; rd_ptr=1, empty=1.
- Backpressure: 5 words 0x01..0x05 written, dout_ready=0 -> exactly 2 reads issued; dout=0x01, skid=0x02, count=3. Raising dout_ready pops 0x01..0x05 in order on consecutive cycles.
- Streaming and wrap: 40 words streamed with dout_ready=1 and writer keeping count<=16 -> one pop per cycle after the initial 2-cycle latency; rd_ptr passes 15->16 and 31->0; no loss or duplication.
- Full storage: wr_ptr=16, rd_ptr=0 -> count=16, empty=0, rd_en=1 (bound by held).
- Pointer error: force wr_ptr=20, rd_ptr=0 -> ptr_err=1 next edge, rd_en=0; buffered words still pop; ptr_err stays set until clear=0.
